// File: rtl/kick_sel_pkg.sv
// Shared types and the bank advance rule for the Kickstart bank selector.
package kick_sel_pkg;

  localparam int SRC_MB = 0;

  typedef enum logic {ARM, STEP} kick_state_e;

  function automatic int src_w(input int nb);
    return $clog2(nb + 1);
  endfunction

  // Smallest enabled source above src, wrapping to the motherboard.
  // Widths are sized for the largest supported bank count.
  function automatic logic [3:0] next_src(input int nb, input logic [3:0] src,
                                          input logic [7:0] en);
    logic [3:0] res;
    logic       found;
    res   = 4'(SRC_MB);
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= nb && !found && 4'(k) > src && en[3'(k - 1)]) begin
        res   = 4'(k);
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/kick_hold_timer.sv
// Hold-duration counter: terminal count at 2^CNT_W-1 (arm) or 2^STEP_W-1 (step).
module kick_hold_timer #(
  parameter int CNT_W  = 20,
  parameter int STEP_W = 19
) (
  input  logic E_CLK,
  input  logic RESET_n,
  input  logic sel_step,
  output logic tc
);
  localparam int CW = (CNT_W > STEP_W) ? CNT_W : STEP_W;
  localparam logic [CW-1:0] TC_ARM  = CW'((64'd1 << CNT_W) - 64'd1);
  localparam logic [CW-1:0] TC_STEP = CW'((64'd1 << STEP_W) - 64'd1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tc    = (cnt_q == (sel_step ? TC_STEP : TC_ARM));
    cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge E_CLK or posedge RESET_n) begin
    if (RESET_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/kick_bank_selector.sv
// Steps the Kickstart source (motherboard / flash banks) while reset is held.
// Optional step LED enabled by defining KICK_BANK_LED_EN.
module kick_bank_selector
  import kick_sel_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int CNT_W     = 20,
  parameter int STEP_W    = 19
) (
  input  logic                                        E_CLK,
  input  logic                                        RESET_n,
  input  logic [NUM_BANKS-1:0]                        BANK_EN,
  output logic                                        USE_MB,
  output logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] BANK_SEL,
  output logic                                        STEP_PULSE,
  output logic                                        LED_n
);
  localparam int SW  = src_w(NUM_BANKS);
  localparam int BSW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  kick_state_e   state_q, state_d;
  logic [SW-1:0] src_q = '0;
  logic [SW-1:0] src_d;
  logic          step_pulse_q, step_pulse_d;
  logic          tc, adv;
  logic [7:0]    en_ext;
  logic [3:0]    src_ext;
  logic [2:0]    idx;

  kick_hold_timer #(.CNT_W(CNT_W), .STEP_W(STEP_W)) u_timer (
    .E_CLK    (E_CLK),
    .RESET_n  (RESET_n),
    .sel_step (state_q == STEP),
    .tc       (tc)
  );

  // Gating with RESET_n keeps a release on the terminal edge from advancing.
  always_comb begin
    adv          = tc & ~RESET_n;
    en_ext       = 8'(BANK_EN);
    src_ext      = 4'(src_q);
    idx          = 3'(src_ext - 4'd1);
    src_d        = adv ? SW'(next_src(NUM_BANKS, src_ext, en_ext)) : src_q;
    step_pulse_d = adv;
    state_d      = state_q;
    if (state_q == ARM && adv) state_d = STEP;
    USE_MB       = (src_q == SW'(SRC_MB)) || !en_ext[idx];
    BANK_SEL     = USE_MB ? '0 : BSW'(idx);
  end

  // Selection survives resets; only the hold logic is cleared.
  always_ff @(posedge E_CLK) src_q <= src_d;

  always_ff @(posedge E_CLK or posedge RESET_n) begin
    if (RESET_n) begin
      state_q      <= ARM;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign STEP_PULSE = step_pulse_q;

`ifdef KICK_BANK_LED_EN
  localparam int LW = STEP_W - 1;
  localparam logic [LW-1:0] LED_LOAD = LW'(64'd1 << (STEP_W - 2));

  logic [LW-1:0] led_cnt_q, led_cnt_d;

  always_comb begin
    led_cnt_d = led_cnt_q;
    if (adv)                  led_cnt_d = LED_LOAD;
    else if (led_cnt_q != '0) led_cnt_d = led_cnt_q - 1'b1;
  end

  always_ff @(posedge E_CLK or posedge RESET_n) begin
    if (RESET_n) led_cnt_q <= '0;
    else         led_cnt_q <= led_cnt_d;
  end

  assign LED_n = !((led_cnt_q != '0) || (RESET_n && src_q != SW'(SRC_MB)));
`else
  assign LED_n = 1'b1;
`endif

endmodule

// File: tb/tb_kick_bank_selector.sv
// Randomized bench for kick_bank_selector against a hold-time reference model.
module tb_kick_bank_selector;
  localparam int NB = 3, CW = 4, SW = 3;
  localparam int FIRST = 1 << CW, PERIOD = 1 << SW;

  logic       E_CLK, RESET_n;
  logic [2:0] BANK_EN;
  logic       USE_MB, STEP_PULSE, LED_n;
  logic [1:0] BANK_SEL;

  int checks = 0, failures = 0;
  int m_src = 0, m_hold = 0, m_led = 0;
  bit m_pulse = 0;

  kick_bank_selector #(.NUM_BANKS(NB), .CNT_W(CW), .STEP_W(SW)) dut (
    .E_CLK(E_CLK), .RESET_n(RESET_n), .BANK_EN(BANK_EN), .USE_MB(USE_MB),
    .BANK_SEL(BANK_SEL), .STEP_PULSE(STEP_PULSE), .LED_n(LED_n)
  );

  initial E_CLK = 1'b0;
  always #5 E_CLK = ~E_CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic int nxt(int s, logic [2:0] en);
    for (int k = s + 1; k <= NB; k++) if (en[k-1]) return k;
    return 0;
  endfunction

  function automatic bit exp_use_mb();
    logic [2:0] e = BANK_EN;
    return (m_src == 0) || !e[m_src-1];
  endfunction

  function automatic logic [1:0] exp_bsel();
    return exp_use_mb() ? 2'd0 : 2'(m_src - 1);
  endfunction

  function automatic bit exp_led_n();
`ifdef KICK_BANK_LED_EN
    return !((m_led > 0) || (RESET_n && m_src != 0));
`else
    return 1'b1;
`endif
  endfunction

  // One E_CLK edge; the model advances on hold lengths FIRST, FIRST+PERIOD, ...
  task automatic tick();
    @(posedge E_CLK);
    m_pulse = 0;
    if (!RESET_n) begin
      if (m_led > 0) m_led--;
      m_hold++;
      if (m_hold == FIRST || (m_hold > FIRST && (m_hold - FIRST) % PERIOD == 0)) begin
        m_src   = nxt(m_src, BANK_EN);
        m_pulse = 1;
        m_led   = 1 << (SW - 2);
      end
    end
    @(negedge E_CLK);
  endtask

  task automatic press();
    RESET_n = 1'b0;
    m_hold  = 0;
  endtask

  task automatic release_rst();
    RESET_n = 1'b1;
    m_hold = 0; m_pulse = 0; m_led = 0;
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (USE_MB !== 1'b1 || BANK_SEL !== 2'd0 || STEP_PULSE !== 1'b0 || LED_n !== 1'b1) begin
      failures++;
      $display("FAIL reset mb=%b sel=%0d pulse=%b led=%b required 1 0 0 1",
               USE_MB, BANK_SEL, STEP_PULSE, LED_n);
    end
  endtask

  task automatic test_short_hold();
    BANK_EN = 3'b111;
    press();
    for (int i = 0; i < FIRST - 1; i++) begin
      tick();
      checks++;
      if (STEP_PULSE !== 1'b0) begin
        failures++;
        $display("FAIL short_hold cyc=%0d pulse=%b required 0", i, STEP_PULSE);
      end
    end
    release_rst();
    checks++;
    if (USE_MB !== 1'b1 || BANK_SEL !== 2'd0) begin
      failures++;
      $display("FAIL short_hold_release mb=%b sel=%0d required 1 0", USE_MB, BANK_SEL);
    end
  endtask

  task automatic test_first_step();
    press();
    for (int i = 1; i <= FIRST + 1; i++) begin
      tick();
      checks++;
      if (STEP_PULSE !== (i == FIRST) || USE_MB !== (i < FIRST)) begin
        failures++;
        $display("FAIL first_step edge=%0d pulse=%b mb=%b required %b %b",
                 i, STEP_PULSE, USE_MB, i == FIRST, i < FIRST);
      end
    end
    release_rst();
    checks++;
    if (USE_MB !== 1'b0 || BANK_SEL !== 2'd0 || STEP_PULSE !== 1'b0) begin
      failures++;
      $display("FAIL first_step_release mb=%b sel=%0d pulse=%b required 0 0 0",
               USE_MB, BANK_SEL, STEP_PULSE);
    end
  endtask

  task automatic test_skip();
    BANK_EN = 3'b101;
    #1;
    press();
    repeat (FIRST) tick();
    release_rst();
    checks++;
    if (USE_MB !== 1'b0 || BANK_SEL !== 2'd2 || m_src != 3) begin
      failures++;
      $display("FAIL skip mb=%b sel=%0d model_src=%0d required 0 2 3", USE_MB, BANK_SEL, m_src);
    end
    BANK_EN = 3'b001;
    #1;
    checks++;
    if (USE_MB !== 1'b1 || BANK_SEL !== 2'd0) begin
      failures++;
      $display("FAIL fallback mb=%b sel=%0d required 1 0", USE_MB, BANK_SEL);
    end
    BANK_EN = 3'b101;
    #1;
    checks++;
    if (USE_MB !== 1'b0 || BANK_SEL !== 2'd2) begin
      failures++;
      $display("FAIL fallback_restore mb=%b sel=%0d required 0 2", USE_MB, BANK_SEL);
    end
  endtask

  task automatic test_no_banks();
    int pulses = 0;
    BANK_EN = 3'b000;
    press();
    for (int i = 1; i <= FIRST + PERIOD; i++) begin
      tick();
      if (STEP_PULSE === 1'b1) pulses++;
      checks++;
      if (STEP_PULSE !== m_pulse || USE_MB !== 1'b1) begin
        failures++;
        $display("FAIL no_banks edge=%0d pulse=%b mb=%b required %b 1",
                 i, STEP_PULSE, USE_MB, m_pulse);
      end
    end
    tick();
    if (STEP_PULSE === 1'b1) pulses++;
    release_rst();
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL no_banks_count pulses=%0d required 2", pulses);
    end
  endtask

  task automatic test_walk();
    BANK_EN = 3'b111;
    press();
    for (int i = 1; i <= FIRST + 3 * PERIOD + 1; i++) begin
      tick();
      checks++;
      if (STEP_PULSE !== m_pulse || USE_MB !== exp_use_mb() || BANK_SEL !== exp_bsel() ||
          LED_n !== exp_led_n()) begin
        failures++;
        $display("FAIL walk edge=%0d pulse=%b mb=%b sel=%0d led=%b required %b %b %0d %b",
                 i, STEP_PULSE, USE_MB, BANK_SEL, LED_n, m_pulse, exp_use_mb(),
                 exp_bsel(), exp_led_n());
      end
    end
    release_rst();
    checks++;
    if (USE_MB !== 1'b1 || m_src != 0) begin
      failures++;
      $display("FAIL walk_release mb=%b model_src=%0d required 1 0", USE_MB, m_src);
    end
  endtask

  task automatic test_led();
    BANK_EN = 3'b111;
    press();
    for (int i = 1; i <= FIRST + PERIOD; i++) begin
      tick();
      checks++;
      if (LED_n !== exp_led_n()) begin
        failures++;
        $display("FAIL led edge=%0d led=%b required %b", i, LED_n, exp_led_n());
      end
    end
    release_rst();
    repeat (3) begin
      tick();
      checks++;
      if (LED_n !== exp_led_n() || STEP_PULSE !== 1'b0) begin
        failures++;
        $display("FAIL led_release led=%b pulse=%b required %b 0", LED_n, STEP_PULSE, exp_led_n());
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int n;
      BANK_EN = 3'($urandom_range(0, 7));
      n = $urandom_range(0, 50);
      press();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) BANK_EN = 3'($urandom_range(0, 7));
        tick();
        checks++;
        if (STEP_PULSE !== m_pulse || USE_MB !== exp_use_mb() || BANK_SEL !== exp_bsel() ||
            LED_n !== exp_led_n()) begin
          failures++;
          $display("FAIL random it=%0d cyc=%0d pulse=%b mb=%b sel=%0d led=%b required %b %b %0d %b",
                   it, i, STEP_PULSE, USE_MB, BANK_SEL, LED_n, m_pulse, exp_use_mb(),
                   exp_bsel(), exp_led_n());
        end
      end
      release_rst();
      tick();
      checks++;
      if (STEP_PULSE !== 1'b0 || USE_MB !== exp_use_mb() || BANK_SEL !== exp_bsel() ||
          LED_n !== exp_led_n()) begin
        failures++;
        $display("FAIL random_release it=%0d pulse=%b mb=%b sel=%0d led=%b required 0 %b %0d %b",
                 it, STEP_PULSE, USE_MB, BANK_SEL, LED_n, exp_use_mb(), exp_bsel(), exp_led_n());
      end
    end
  endtask

  initial begin
    RESET_n = 1'b1;
    BANK_EN = 3'b000;
    repeat (2) @(negedge E_CLK);
    test_reset();
    test_short_hold();
    test_first_step();
    test_skip();
    test_no_banks();
    test_walk();
    test_led();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
